moving_sum_window: RTL and testbench

Running-sum stage placed directly upstream of the power-of-two divider. It keeps the last DEPTH unsigned samples in a circular buffer and outputs their sum each time a new sample arrives. When the divider is configured with DIVIDE = DEPTH, the pair forms a moving-average filter. The output is widened so the sum never overflows.

---
 rtl/movsum_pkg.sv | 17 +
 rtl/sample_ring_buffer.sv | 36 +++
 rtl/moving_sum_window.sv | 99 +++++++++
 tb/tb_moving_sum_window.sv | 126 ++++++++++++
 4 files changed

// File: rtl/movsum_pkg.sv
// rtl/movsum_pkg.sv - shared types, defaults and width helper for moving_sum_window
package movsum_pkg;

    localparam int DEFAULT_BITS  = 8;
    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic {
        FILLING = 1'b0,
        FULL    = 1'b1
    } movsum_state_t;

    // Widening needed so that DEPTH full-scale samples never overflow the sum
    function automatic int sum_width(input int bits, input int depth);
        return bits + $clog2(depth);
    endfunction

endpackage

// File: rtl/sample_ring_buffer.sv
// rtl/sample_ring_buffer.sv - DEPTH x BITS circular sample store with read-before-write old sample
module sample_ring_buffer #(
    parameter int BITS  = 8,
    parameter int DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_we,
    input  logic            i_clear,
    input  logic [BITS-1:0] i_din,
    output logic [BITS-1:0] o_old
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [BITS-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;

    // The entry about to be overwritten is the one leaving the window
    assign o_old = mem[wr_ptr];

    // Storage and write pointer; clear flushes entries so partial sums stay exact
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
        end else if (i_clear) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
        end else if (i_we) begin
            mem[wr_ptr] <= i_din;
            wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/moving_sum_window.sv
// rtl/moving_sum_window.sv - running sum of last DEPTH samples; MOVSUM_FILL_GATE_EN gates o_valid during fill
module moving_sum_window
    import movsum_pkg::*;
#(
    parameter  int BITS  = DEFAULT_BITS,
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int SUM_W = sum_width(BITS, DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [BITS-1:0]  i_Din,
    input  logic             i_valid,
    input  logic             i_clear,
    output logic [SUM_W-1:0] o_Dout,
    output logic             o_valid,
    output logic             o_full
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
            $fatal(1, "moving_sum_window: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [BITS-1:0]  old_sample;
    logic [SUM_W-1:0] sum_q;
    logic [SUM_W-1:0] sum_next;
    logic [CNT_W-1:0] count_q;
    logic             accept;
    logic             valid_next;
    movsum_state_t    state_q;
    movsum_state_t    state_next;

    // A sample is dropped when it coincides with a flush
    assign accept = i_valid && !i_clear;

    sample_ring_buffer #(
        .BITS  (BITS),
        .DEPTH (DEPTH)
    ) u_ring (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (accept),
        .i_clear (i_clear),
        .i_din   (i_Din),
        .o_old   (old_sample)
    );

    assign sum_next = sum_q + SUM_W'(i_Din) - SUM_W'(old_sample);

    // Next state and output-valid qualification
    always_comb begin
        state_next = state_q;
        if (i_clear) begin
            state_next = FILLING;
        end else if (accept && state_q == FILLING && count_q == CNT_W'(DEPTH - 1)) begin
            state_next = FULL;
        end
`ifdef MOVSUM_FILL_GATE_EN
        valid_next = accept && (state_next == FULL);
`else
        valid_next = accept;
`endif
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= FILLING;
        end else begin
            state_q <= state_next;
        end
    end

    // Sum, fill count and valid pulse
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sum_q   <= '0;
            count_q <= '0;
            o_valid <= 1'b0;
        end else if (i_clear) begin
            sum_q   <= '0;
            count_q <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= valid_next;
            if (accept) begin
                sum_q <= sum_next;
                if (count_q != CNT_W'(DEPTH)) count_q <= count_q + 1'b1;
            end
        end
    end

    assign o_Dout = sum_q;
    assign o_full = (state_q == FULL);

endmodule

// File: tb/tb_moving_sum_window.sv
// tb/tb_moving_sum_window.sv - directed self-checking bench for moving_sum_window
module tb_moving_sum_window;

    localparam int BITS  = 8;
    localparam int DEPTH = 4;
    localparam int SUM_W = 10;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic [BITS-1:0]  i_Din;
    logic             i_valid;
    logic             i_clear;
    logic [SUM_W-1:0] o_Dout;
    logic             o_valid;
    logic             o_full;

    int checks   = 0;
    int failures = 0;

    moving_sum_window #(
        .BITS  (BITS),
        .DEPTH (DEPTH)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_Din   (i_Din),
        .i_valid (i_valid),
        .i_clear (i_clear),
        .o_Dout  (o_Dout),
        .o_valid (o_valid),
        .o_full  (o_full)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs at a falling edge, then check outputs at the next falling edge
    task automatic step(input string tag, input logic v, input int d, input logic c,
                        input int exp_valid, input int exp_dout, input int exp_full);
        i_valid = v;
        i_Din   = d[BITS-1:0];
        i_clear = c;
        @(negedge i_clk);
        check({tag, ".valid"}, int'(o_valid), exp_valid);
        check({tag, ".dout"},  int'(o_Dout),  exp_dout);
        check({tag, ".full"},  int'(o_full),  exp_full);
    endtask

    int fill_in  [4] = '{10, 20, 30, 40};
    int fill_exp [4] = '{10, 30, 60, 100};
    int max_exp  [6] = '{255, 510, 765, 1020, 1020, 1020};
    int g_in     [5] = '{1, 2, 3, 4, 5};
    int g_sum    [5] = '{1, 3, 6, 10, 14};

    initial begin
        i_rst   = 1'b1;
        i_Din   = '0;
        i_valid = 1'b0;
        i_clear = 1'b0;
        repeat (2) @(negedge i_clk);
        check("rst.valid", int'(o_valid), 0);
        check("rst.dout",  int'(o_Dout),  0);
        check("rst.full",  int'(o_full),  0);
        i_rst = 1'b0;
        @(negedge i_clk);

        // Fill then slide
        for (int i = 0; i < 4; i++)
            step($sformatf("fill%0d", i), 1'b1, fill_in[i], 1'b0, 1, fill_exp[i], (i == 3) ? 1 : 0);
        step("slide50", 1'b1, 50, 1'b0, 1, 140, 1);
        step("slide60", 1'b1, 60, 1'b0, 1, 180, 1);

        // Asynchronous reset mid-cycle, observed before any clock edge
        i_valid = 1'b0;
        #2 i_rst = 1'b1;
        #1;
        check("arst.valid", int'(o_valid), 0);
        check("arst.dout",  int'(o_Dout),  0);
        check("arst.full",  int'(o_full),  0);
        @(negedge i_clk);
        i_rst = 1'b0;

        // Full-scale samples, no wrap at 10 bits
        for (int i = 0; i < 6; i++)
            step($sformatf("max%0d", i), 1'b1, 255, 1'b0, 1, max_exp[i], (i >= 3) ? 1 : 0);

        step("clr1", 1'b0, 0, 1'b1, 0, 0, 0);

        // Gaps: output holds and valid drops while idle
        step("gap7", 1'b1, 7, 1'b0, 1, 7, 0);
        for (int i = 0; i < 3; i++)
            step($sformatf("idle%0d", i), 1'b0, 0, 1'b0, 0, 7, 0);
        step("gap9", 1'b1, 9, 1'b0, 1, 16, 0);

        step("clr2", 1'b0, 0, 1'b1, 0, 0, 0);

        // Clear wins over a coincident sample
        for (int i = 0; i < 4; i++)
            step($sformatf("cfill%0d", i), 1'b1, fill_in[i], 1'b0, 1, fill_exp[i], (i == 3) ? 1 : 0);
        step("clr_drop", 1'b1, 99, 1'b1, 0, 0, 0);
        step("after_clr", 1'b1, 5, 1'b0, 1, 5, 0);

        step("clr3", 1'b0, 0, 1'b1, 0, 0, 0);

        // Fill gating: only sums of a full window pulse valid when enabled
        for (int i = 0; i < 5; i++) begin
`ifdef MOVSUM_FILL_GATE_EN
            step($sformatf("gate%0d", i), 1'b1, g_in[i], 1'b0, (i >= 3) ? 1 : 0, g_sum[i], (i >= 3) ? 1 : 0);
`else
            step($sformatf("gate%0d", i), 1'b1, g_in[i], 1'b0, 1, g_sum[i], (i >= 3) ? 1 : 0);
`endif
        end
        step("tail_idle", 1'b0, 0, 1'b0, 0, 14, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
